etc_frame_buffer: RTL and testbench

ETC_FRAME_BUFFER -- requirements
Module: etc_frame_buffer

---
 rtl/etc_frame_buffer.sv | 197 +++++++++++++++++++
 tb/tb_etc_frame_buffer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/etc_frame_buffer.sv
// etc_frame_buffer
//   Double-buffered frame store between an ETC2 block decoder and a raster
//   display. Decoded pixels arrive in 4x4 block order and are written into the
//   back bank of an external RAM in raster order. The display reads the front
//   bank. Banks swap on vsync once a full frame has been written.
//
// Ports
//   sclk, rsrt            : clock, synchronous active-low reset
//   pix_valid/pix_ready   : decoded-pixel handshake; r, g, b pixel colour
//   ram_we/waddr/wdata    : RAM write port (combinational on acceptance)
//   ram_raddr/ram_rdata   : RAM read port, data one cycle after address
//   disp_vsync            : frame boundary from the display
//   disp_en/disp_x/disp_y : display pixel request
//   rgb_out/rgb_out_valid : display pixel result
//   frame_done            : pulse on acceptance of the last pixel of a frame
//   back_bank             : bank currently being written
module etc_frame_buffer #(
   parameter int  IMG_W   = 128,
   parameter int  IMG_H   = 128,
   parameter int  PIX_FMT = 0,
   localparam int XW      = $clog2(IMG_W),
   localparam int YW      = $clog2(IMG_H),
   localparam int ADDR_W  = 1 + YW + XW,
   localparam int DATA_W  = (PIX_FMT == 1) ? 24 : 16
) (
   input  logic              sclk,
   input  logic              rsrt,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic [7:0]        r,
   input  logic [7:0]        g,
   input  logic [7:0]        b,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_waddr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic [ADDR_W-1:0] ram_raddr,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic              disp_vsync,
   input  logic              disp_en,
   input  logic [XW-1:0]     disp_x,
   input  logic [YW-1:0]     disp_y,
   output logic [DATA_W-1:0] rgb_out,
   output logic              rgb_out_valid,
   output logic              frame_done,
   output logic              back_bank
);

   // Block counters keep at least one bit so a 4-pixel-wide image still
   // elaborates; the wrap compare against *_MAX handles that case.
   localparam int BXW = (XW > 2) ? XW - 2 : 1;
   localparam int BYW = (YW > 2) ? YW - 2 : 1;
   localparam logic [BXW-1:0] BX_MAX = BXW'(IMG_W / 4 - 1);
   localparam logic [BYW-1:0] BY_MAX = BYW'(IMG_H / 4 - 1);

   typedef enum logic {
      S_FILL = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t            state_q;
   logic              back_bank_q;
   logic              has_frame_q;
   logic [3:0]        p_q, p_d;
   logic [BXW-1:0]    bx_q, bx_d;
   logic [BYW-1:0]    by_q, by_d;
   logic              accept;
   logic              last_pix;
   logic [XW-1:0]     wr_col;
   logic [YW-1:0]     wr_row;

   // Read pipeline: stage 1 holds the registered address, stage 2 waits for
   // the RAM, then rgb_out captures the data.
   logic [ADDR_W-1:0] raddr_q, raddr_d;
   logic              rd_v1_q, rd_v1_d;
   logic              rd_blank1_q, rd_blank1_d;
   logic              rd_v2_q, rd_v2_d;
   logic              rd_blank2_q, rd_blank2_d;
   logic [DATA_W-1:0] rgb_out_q, rgb_out_d;
   logic              rgb_valid_q, rgb_valid_d;

   assign pix_ready = (state_q == S_FILL);
   assign accept    = pix_valid & pix_ready;
   assign last_pix  = (p_q == 4'hF) && (bx_q == BX_MAX) && (by_q == BY_MAX);

   // Within a 4x4 block, p[1:0] is the column and p[3:2] the row.
   assign wr_col = (XW'(bx_q) << 2) | XW'(p_q[1:0]);
   assign wr_row = (YW'(by_q) << 2) | YW'(p_q[3:2]);

   assign ram_we     = accept;
   assign ram_waddr  = {back_bank_q, wr_row, wr_col};
   assign frame_done = accept & last_pix;
   assign back_bank  = back_bank_q;
   assign ram_raddr  = raddr_q;
   assign rgb_out    = rgb_out_q;
   assign rgb_out_valid = rgb_valid_q;

   generate
      if (PIX_FMT == 1) begin : g_rgb888
         assign ram_wdata = {r, g, b};
      end else begin : g_rgb565
         logic unused_low_bits;
         assign ram_wdata       = {r[7:3], g[7:2], b[7:3]};
         assign unused_low_bits = ^{r[2:0], g[1:0], b[2:0]};
      end
   endgenerate

   always_comb begin
      p_d  = p_q;
      bx_d = bx_q;
      by_d = by_q;
      if (accept) begin
         p_d = p_q + 4'd1;
         if (p_q == 4'hF) begin
            if (bx_q == BX_MAX) begin
               bx_d = '0;
               by_d = (by_q == BY_MAX) ? '0 : by_q + BYW'(1);
            end else begin
               bx_d = bx_q + BXW'(1);
            end
         end
      end
   end

   always_ff @(posedge sclk) begin
      if (!rsrt) begin
         p_q  <= '0;
         bx_q <= '0;
         by_q <= '0;
      end else begin
         p_q  <= p_d;
         bx_q <= bx_d;
         by_q <= by_d;
      end
   end

   // Bank control. vsync only matters once a complete frame is waiting, so a
   // vsync on the same cycle as the last pixel is deliberately not honoured.
   always_ff @(posedge sclk) begin
      if (!rsrt) begin
         state_q     <= S_FILL;
         back_bank_q <= 1'b0;
         has_frame_q <= 1'b0;
      end else begin
         case (state_q)
            S_FILL: begin
               if (accept && last_pix) begin
                  state_q <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (disp_vsync) begin
                  state_q     <= S_FILL;
                  back_bank_q <= ~back_bank_q;
                  has_frame_q <= 1'b1;
               end
            end
            default: state_q <= S_FILL;
         endcase
      end
   end

   // The blanking decision travels with each request so that a swap landing
   // mid-pipeline cannot change the meaning of a read already issued.
   always_comb begin
      raddr_d     = disp_en ? {~back_bank_q, disp_y, disp_x} : raddr_q;
      rd_v1_d     = disp_en;
      rd_blank1_d = ~has_frame_q;
      rd_v2_d     = rd_v1_q;
      rd_blank2_d = rd_blank1_q;
      rgb_valid_d = rd_v2_q;
      rgb_out_d   = rgb_out_q;
      if (rd_v2_q) begin
         rgb_out_d = rd_blank2_q ? '0 : ram_rdata;
      end
   end

   always_ff @(posedge sclk) begin
      if (!rsrt) begin
         raddr_q     <= '0;
         rd_v1_q     <= 1'b0;
         rd_blank1_q <= 1'b1;
         rd_v2_q     <= 1'b0;
         rd_blank2_q <= 1'b1;
         rgb_out_q   <= '0;
         rgb_valid_q <= 1'b0;
      end else begin
         raddr_q     <= raddr_d;
         rd_v1_q     <= rd_v1_d;
         rd_blank1_q <= rd_blank1_d;
         rd_v2_q     <= rd_v2_d;
         rd_blank2_q <= rd_blank2_d;
         rgb_out_q   <= rgb_out_d;
         rgb_valid_q <= rgb_valid_d;
      end
   end

endmodule

// File: tb/tb_etc_frame_buffer.sv
// tb_etc_frame_buffer
//   Drives an 8x8 RGB565 instance of etc_frame_buffer with directed vectors.
//   A frame-level model (pixel index -> raster position, two image banks,
//   a schedule of expected display results) is checked against the outputs on
//   every falling edge; literal expectations pin the model at key points.
module tb_etc_frame_buffer;

   localparam int W  = 8;
   localparam int H  = 8;
   localparam int AW = 7;
   localparam int DW = 16;
   localparam int NPIX = W * H;

   logic          sclk = 1'b0;
   logic          rsrt;
   logic          pix_valid;
   logic          pix_ready;
   logic [7:0]    r, g, b;
   logic          ram_we;
   logic [AW-1:0] ram_waddr;
   logic [DW-1:0] ram_wdata;
   logic [AW-1:0] ram_raddr;
   logic [DW-1:0] ram_rdata;
   logic          disp_vsync;
   logic          disp_en;
   logic [2:0]    disp_x, disp_y;
   logic [DW-1:0] rgb_out;
   logic          rgb_out_valid;
   logic          frame_done;
   logic          back_bank;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always #5 sclk = ~sclk;

   etc_frame_buffer #(.IMG_W(W), .IMG_H(H), .PIX_FMT(0)) dut (
      .sclk(sclk), .rsrt(rsrt),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .r(r), .g(g), .b(b),
      .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
      .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
      .disp_vsync(disp_vsync), .disp_en(disp_en),
      .disp_x(disp_x), .disp_y(disp_y),
      .rgb_out(rgb_out), .rgb_out_valid(rgb_out_valid),
      .frame_done(frame_done), .back_bank(back_bank)
   );

   // External RAM: synchronous write, one-cycle registered read.
   logic [DW-1:0] mem [2*NPIX];
   initial begin
      for (int i = 0; i < 2 * NPIX; i++) mem[i] = '0;
   end
   always @(posedge sclk) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      ram_rdata <= mem[ram_raddr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [15:0] pack565(input logic [7:0] rr, input logic [7:0] gg,
                                           input logic [7:0] bb);
      return {rr[7:3], gg[7:2], bb[7:3]};
   endfunction

   // Raster address of the n-th pixel of a frame delivered in 4x4 block order.
   function automatic int raster_index(input int n);
      int blk, p, x, y;
      blk = n / 16;
      p   = n % 16;
      x   = (blk % (W / 4)) * 4 + (p % 4);
      y   = (blk / (W / 4)) * 4 + (p / 4);
      return y * W + x;
   endfunction

   // ---------------- frame-level model ----------------
   bit            m_fill = 1'b1;
   int            m_count = 0;
   bit            m_back = 1'b0;
   bit            m_has = 1'b0;
   logic [15:0]   m_img [2][NPIX];
   bit            pend_v [4];
   logic [15:0]   pend_d [4];
   bit            exp_v = 1'b0;
   logic [15:0]   exp_rgb = '0;

   always @(posedge sclk) begin
      int slot;
      cyc++;
      if (!rsrt) begin
         m_fill  = 1'b1;
         m_count = 0;
         m_back  = 1'b0;
         m_has   = 1'b0;
         for (int i = 0; i < 4; i++) pend_v[i] = 1'b0;
         exp_v   = 1'b0;
         exp_rgb = '0;
      end else begin
         if (disp_en) begin
            slot = (cyc + 2) % 4;
            pend_v[slot] = 1'b1;
            pend_d[slot] = m_has ? m_img[!m_back][int'(disp_y) * W + int'(disp_x)] : 16'h0;
         end
         if (pix_valid && m_fill) begin
            m_img[m_back][raster_index(m_count)] = pack565(r, g, b);
            if (m_count == NPIX - 1) begin
               m_fill  = 1'b0;
               m_count = 0;
            end else begin
               m_count++;
            end
         end else if (!m_fill && disp_vsync) begin
            m_fill = 1'b1;
            m_back = !m_back;
            m_has  = 1'b1;
         end
         slot  = cyc % 4;
         exp_v = pend_v[slot];
         if (exp_v) exp_rgb = pend_d[slot];
         pend_v[slot] = 1'b0;
      end
   end

   always @(negedge sclk) begin
      bit e_we;
      if (cyc >= 1) begin
         e_we = pix_valid && m_fill;
         check("pix_ready", 32'(pix_ready), 32'(m_fill));
         check("ram_we", 32'(ram_we), 32'(e_we));
         if (e_we) begin
            check("ram_waddr", 32'(ram_waddr), 32'(int'(m_back) * NPIX + raster_index(m_count)));
            check("ram_wdata", 32'(ram_wdata), 32'(pack565(r, g, b)));
            $display("[TB] cyc %0d write bank %0d addr 0x%02h data 0x%04h",
                     cyc, m_back, ram_waddr, ram_wdata);
         end
         check("frame_done", 32'(frame_done), 32'(e_we && (m_count == NPIX - 1)));
         check("back_bank", 32'(back_bank), 32'(m_back));
         check("rgb_out_valid", 32'(rgb_out_valid), 32'(exp_v));
         check("rgb_out", 32'(rgb_out), 32'(exp_rgb));
         if (exp_v) $display("[TB] cyc %0d display pixel 0x%04h", cyc, rgb_out);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic set_pixel(input int n);
      logic [7:0] nn;
      nn = 8'(n);
      if (n == 0) begin
         r = 8'hFF; g = 8'h00; b = 8'hFF;
      end else begin
         r = nn << 3;
         g = nn << 2;
         b = (~nn) << 3;
      end
   endtask

   initial begin
      rsrt = 1'b0; pix_valid = 1'b0; r = '0; g = '0; b = '0;
      disp_vsync = 1'b0; disp_en = 1'b0; disp_x = '0; disp_y = '0;

      // Reset state
      repeat (2) tick();
      rsrt = 1'b1;
      #3;
      check("rst pix_ready", 32'(pix_ready), 32'd1);
      check("rst back_bank", 32'(back_bank), 32'd0);
      check("rst rgb_out_valid", 32'(rgb_out_valid), 32'd0);
      check("rst frame_done", 32'(frame_done), 32'd0);
      check("rst ram_we", 32'(ram_we), 32'd0);

      // Display request with no completed frame: blank output, valid still set
      tick();
      disp_en = 1'b1; disp_x = 3'd3; disp_y = 3'd2;
      tick();
      disp_en = 1'b0;
      #3 check("raddr pre-swap", 32'(ram_raddr), 32'h53);
      check("valid +1", 32'(rgb_out_valid), 32'd0);
      tick();
      tick();
      #3 check("blank valid", 32'(rgb_out_valid), 32'd1);
      check("blank rgb", 32'(rgb_out), 32'd0);

      // First frame, vsync coincident with the final pixel
      for (int n = 0; n < NPIX; n++) begin
         tick();
         pix_valid  = 1'b1;
         set_pixel(n);
         disp_vsync = (n == NPIX - 1);
         #3;
         if (n == 0) begin
            check("px0 waddr", 32'(ram_waddr), 32'h00);
            check("px0 wdata", 32'(ram_wdata), 32'hF81F);
            check("px0 we", 32'(ram_we), 32'd1);
         end
         if (n == 4)  check("px4 waddr", 32'(ram_waddr), 32'h08);
         if (n == 16) check("px16 waddr", 32'(ram_waddr), 32'h04);
         if (n == NPIX - 1) check("px63 frame_done", 32'(frame_done), 32'd1);
      end
      tick();
      disp_vsync = 1'b0;
      set_pixel(1);
      #3 check("hold pix_ready", 32'(pix_ready), 32'd0);
      check("hold ram_we", 32'(ram_we), 32'd0);
      check("no swap on coincident vsync", 32'(back_bank), 32'd0);
      tick();
      disp_vsync = 1'b1;
      tick();
      disp_vsync = 1'b0;
      #3 check("swap back_bank", 32'(back_bank), 32'd1);
      check("swap pix_ready", 32'(pix_ready), 32'd1);
      check("frame2 px0 waddr", 32'(ram_waddr), 32'h40);

      // Second frame writes overlap with display reads of the first frame
      for (int i = 1; i < 20; i++) begin
         tick();
         set_pixel(i + 1);
         disp_en = (i <= 9);
         if (i == 1) begin
            disp_x = 3'd3; disp_y = 3'd2;
         end else begin
            disp_x = 3'(i - 2); disp_y = 3'd5;
         end
         #3;
         if (i == 2) check("raddr post-swap", 32'(ram_raddr), 32'h13);
         if (i == 4) begin
            check("post-swap valid", 32'(rgb_out_valid), 32'd1);
            check("post-swap rgb", 32'(rgb_out), 32'h5974);
         end
      end

      // Reset mid-frame with a read still in flight
      tick();
      pix_valid = 1'b0;
      disp_en = 1'b1; disp_x = 3'd1; disp_y = 3'd1;
      tick();
      disp_en = 1'b0;
      rsrt = 1'b0;
      tick();
      rsrt = 1'b1;
      #3 check("mid rst back_bank", 32'(back_bank), 32'd0);
      check("mid rst pix_ready", 32'(pix_ready), 32'd1);
      check("mid rst rgb_out", 32'(rgb_out), 32'd0);
      check("mid rst valid", 32'(rgb_out_valid), 32'd0);
      tick();
      pix_valid = 1'b1;
      set_pixel(5);
      #3 check("flushed valid", 32'(rgb_out_valid), 32'd0);
      check("after rst waddr", 32'(ram_waddr), 32'h00);
      check("after rst we", 32'(ram_we), 32'd1);
      tick();
      pix_valid = 1'b0;
      repeat (4) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
